// File: rtl/mmio_fifo_pkg.sv
// Shared constants and types for the MMIO FIFO controller.
// Optional push counter is enabled by defining MMIO_FIFO_CTRL_PERF_EN.
package mmio_fifo_pkg;

    // Default register window (DWORD addresses)
    localparam logic [15:0] DEF_DATA_ADDR   = 16'h0020;
    localparam logic [15:0] DEF_STATUS_ADDR = 16'h0022;
    localparam logic [15:0] DEF_CTRL_ADDR   = 16'h0024;
    localparam logic [15:0] DEF_PERF_ADDR   = 16'h0026;

    typedef enum logic {IDLE, FLUSH} t_fifo_ctrl_state;

    // STATUS register layout
    localparam int ST_FILL_LSB  = 0;
    localparam int ST_FULL_BIT  = 8;
    localparam int ST_EMPTY_BIT = 9;
    localparam int ST_BUSY_BIT  = 10;
    localparam int ST_DROP_LSB  = 16;

    // CTRL command bits
    localparam int CTRL_FLUSH_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;

    // Assemble the STATUS word from controller state
    function automatic logic [63:0] pack_status(input logic [7:0]  fill,
                                                input logic        busy,
                                                input logic [15:0] drop,
                                                input logic [7:0]  depth);
        logic [63:0] s;
        s = '0;
        s[ST_FILL_LSB +: 8]  = fill;
        s[ST_FULL_BIT]       = (fill == depth);
        s[ST_EMPTY_BIT]      = (fill == 8'd0);
        s[ST_BUSY_BIT]       = busy;
        s[ST_DROP_LSB +: 16] = drop;
        return s;
    endfunction

endpackage

// File: rtl/mmio_fifo_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up, stick at all-ones, never wrap
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO front end for an external DEPTH-stage shift-register FIFO.
// Decodes pushes/commands, tracks fill and drops, runs the flush FSM and
// returns 1-cycle read responses for its register window.
// Define MMIO_FIFO_CTRL_PERF_EN to add the 32-bit push counter at PERF_ADDR.
module mmio_fifo_ctrl
    import mmio_fifo_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DATA_ADDR   = DEF_DATA_ADDR,
    parameter logic [15:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [15:0] CTRL_ADDR   = DEF_CTRL_ADDR,
    parameter logic [15:0] PERF_ADDR   = DEF_PERF_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic [15:0] mmio_wr_addr,
    input  logic [63:0] mmio_wr_data,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_rd_addr,
    input  logic [8:0]  mmio_rd_tid,
    output logic        fifo_en,
    output logic [63:0] fifo_d,
    input  logic [63:0] fifo_q,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data,
    output logic        busy
);

    localparam int          FC_W    = $clog2(DEPTH);
    localparam logic [7:0]  DEPTH_V = 8'(DEPTH);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(DEPTH - 1);

    t_fifo_ctrl_state state;
    logic [7:0]       fill;
    logic [FC_W-1:0]  flush_cnt;
    logic [15:0]      drop_cnt;

    logic wr_data_hit, wr_ctrl_hit, full, drop_inc, drop_clr;
    logic rd_hit;
    logic [63:0] rd_val;

    assign wr_data_hit = mmio_wr_valid && (mmio_wr_addr == DATA_ADDR);
    assign wr_ctrl_hit = mmio_wr_valid && (mmio_wr_addr == CTRL_ADDR);
    assign full        = (fill == DEPTH_V);
    // A push while full evicts the oldest stage; a push during flush is lost
    assign drop_inc    = wr_data_hit && ((state == FLUSH) || full);
    assign drop_clr    = wr_ctrl_hit && mmio_wr_data[CTRL_CLR_BIT];

    sat_counter #(.W(16)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .clr (drop_clr),
        .cnt (drop_cnt)
    );

`ifdef MMIO_FIFO_CTRL_PERF_EN
    logic [31:0] push_cnt;

    // Count accepted pushes only; flush shifts are not pushes
    always_ff @(posedge clk) begin
        if (rst || drop_clr)
            push_cnt <= '0;
        else if (wr_data_hit && (state == IDLE))
            push_cnt <= push_cnt + 32'd1;
    end
`endif

    // Flush FSM plus FIFO drive; fifo_en/busy stay aligned with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fill      <= '0;
            flush_cnt <= '0;
            fifo_en   <= 1'b0;
            fifo_d    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ctrl_hit && mmio_wr_data[CTRL_FLUSH_BIT]) begin
                        state     <= FLUSH;
                        busy      <= 1'b1;
                        fifo_en   <= 1'b1;
                        fifo_d    <= '0;
                        flush_cnt <= '0;
                        fill      <= '0;
                    end else if (wr_data_hit) begin
                        fifo_en <= 1'b1;
                        fifo_d  <= mmio_wr_data;
                        if (!full)
                            fill <= fill + 8'd1;
                    end else begin
                        fifo_en <= 1'b0;
                    end
                end
                FLUSH: begin
                    fill   <= '0;
                    fifo_d <= '0;
                    if (flush_cnt == FC_LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        fifo_en <= 1'b0;
                    end else begin
                        fifo_en   <= 1'b1;
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read decode against pre-write state of this cycle
    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        if (mmio_rd_valid) begin
            if (mmio_rd_addr == DATA_ADDR) begin
                rd_hit = 1'b1;
                rd_val = full ? fifo_q : 64'd0;
            end else if (mmio_rd_addr == STATUS_ADDR) begin
                rd_hit = 1'b1;
                rd_val = pack_status(fill, busy, drop_cnt, DEPTH_V);
            end else if (mmio_rd_addr == CTRL_ADDR) begin
                rd_hit = 1'b1;
            end
`ifdef MMIO_FIFO_CTRL_PERF_EN
            else if (mmio_rd_addr == PERF_ADDR) begin
                rd_hit = 1'b1;
                rd_val = {32'd0, push_cnt};
            end
`endif
        end
    end

    // One-cycle read response; unmapped reads are left to the parent
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_hit;
            if (rd_hit) begin
                rsp_tid  <= mmio_rd_tid;
                rsp_data <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed bench for mmio_fifo_ctrl (DEPTH=8) with a behavioural shift-register FIFO.
module tb_mmio_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam logic [15:0] A_DATA = 16'h0020, A_STAT = 16'h0022,
                            A_CTRL = 16'h0024, A_PERF = 16'h0026;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, rd_valid;
    logic [15:0] wr_addr, rd_addr;
    logic [63:0] wr_data;
    logic [8:0]  rd_tid;
    logic        fifo_en, rsp_valid, busy;
    logic [63:0] fifo_d, fifo_q, rsp_data;
    logic [8:0]  rsp_tid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mmio_wr_valid(wr_valid), .mmio_wr_addr(wr_addr), .mmio_wr_data(wr_data),
        .mmio_rd_valid(rd_valid), .mmio_rd_addr(rd_addr), .mmio_rd_tid(rd_tid),
        .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q),
        .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
        .busy(busy)
    );

    // External FIFO: stage 0 takes fifo_d, last stage is the oldest
    logic [63:0] fmem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) fmem[i] <= '0;
        end else if (fifo_en) begin
            for (int i = DEPTH - 1; i > 0; i--) fmem[i] <= fmem[i-1];
            fmem[0] <= fifo_d;
        end
    end
    assign fifo_q = fmem[DEPTH-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [8:0] tid,
                      input logic expv, input logic [63:0] expd);
        rd_valid = 1'b1; rd_addr = a; rd_tid = tid;
        step();
        rd_valid = 1'b0;
        chk({tag, "_vld"}, 64'(rsp_valid), 64'(expv));
        if (expv) begin
            chk({tag, "_tid"}, 64'(rsp_tid), 64'(tid));
            chk({tag, "_data"}, rsp_data, expd);
        end
    endtask

    initial begin
        int n, bad;
        rst = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; rd_tid = '0;
        step(); step();
        chk("rst_fifo_en", 64'(fifo_en), 64'd0);
        chk("rst_fifo_d", fifo_d, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_tid", 64'(rsp_tid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Empty status, TID echo, one-cycle pulse
        rd("stat0", A_STAT, 9'h1A, 1'b1, 64'h200);
        step();
        chk("rsp_pulse", 64'(rsp_valid), 64'd0);

        // Fill to DEPTH with 1..8
        wr(A_DATA, 64'd1);
        chk("push_en", 64'(fifo_en), 64'd1);
        chk("push_d", fifo_d, 64'd1);
        for (int v = 2; v <= 8; v++) wr(A_DATA, 64'(v));
        step();
        chk("idle_en", 64'(fifo_en), 64'd0);
        rd("data_full", A_DATA, 9'h002, 1'b1, 64'd1);
        rd("stat_full", A_STAT, 9'h003, 1'b1, 64'h108);

        // Overflow push evicts oldest and counts a drop
        wr(A_DATA, 64'd9);
        step();
        rd("data_ovf", A_DATA, 9'h004, 1'b1, 64'd2);
        rd("stat_ovf", A_STAT, 9'h005, 1'b1, 64'h1_0108);

        // Flush: 8 cycles of zero shifts, DATA write during flush dropped
        wr(A_CTRL, 64'h1);
        n = (busy && fifo_en && fifo_d == 64'd0) ? 1 : 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin wr_valid = 1'b1; wr_addr = A_DATA; wr_data = 64'hAA; end
            step();
            wr_valid = 1'b0;
            if (!busy) break;
            n++;
            if (!fifo_en || fifo_d !== 64'd0) bad++;
        end
        chk("flush_len", 64'(n), 64'd8);
        chk("flush_shift", 64'(bad), 64'd0);
        chk("flush_end_en", 64'(fifo_en), 64'd0);
        rd("stat_flush", A_STAT, 9'h006, 1'b1, 64'h2_0200);

        // Same-cycle read+write at fill=3: read sees not-full
        wr(A_DATA, 64'd10); wr(A_DATA, 64'd11); wr(A_DATA, 64'd12);
        step();
        rd_valid = 1'b1; rd_addr = A_DATA; rd_tid = 9'h007;
        wr_valid = 1'b1; wr_addr = A_DATA; wr_data = 64'd13;
        step();
        rd_valid = 1'b0; wr_valid = 1'b0;
        chk("rw_vld", 64'(rsp_valid), 64'd1);
        chk("rw_data", rsp_data, 64'd0);
        chk("rw_push_d", fifo_d, 64'd13);
        step();
        rd("stat_rw", A_STAT, 9'h008, 1'b1, 64'h2_0004);

        // Unmapped write has no effect; CTRL reads 0; unmapped read silent
        wr(16'h0030, 64'hFFFF);
        rd("stat_unmap", A_STAT, 9'h009, 1'b1, 64'h2_0004);
        rd("ctrl_rd", A_CTRL, 9'h00A, 1'b1, 64'd0);
        rd("unmap_rd", 16'h0030, 9'h00B, 1'b0, 64'd0);

        // Reset during flush cycle 3
        wr(A_CTRL, 64'h1);
        chk("flush2_busy", 64'(busy), 64'd1);
        step(); step();
        rst = 1'b1;
        step();
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_en", 64'(fifo_en), 64'd0);
        rst = 1'b0;
        rd("stat_rstmid", A_STAT, 9'h00C, 1'b1, 64'h200);

        // Five flush-time drops, then clear via CTRL bit 1
        wr(A_CTRL, 64'h1);
        for (int i = 0; i < 5; i++) wr(A_DATA, 64'hBB);
        for (int i = 0; i < 20 && busy; i++) step();
        chk("flush3_done", 64'(busy), 64'd0);
        rd("stat_drop5", A_STAT, 9'h00D, 1'b1, 64'h5_0200);
        wr(A_CTRL, 64'h2);
        chk("clr_no_flush", 64'(busy), 64'd0);
        rd("stat_clr", A_STAT, 9'h00E, 1'b1, 64'h200);

`ifdef MMIO_FIFO_CTRL_PERF_EN
        for (int v = 0; v < 10; v++) wr(A_DATA, 64'(v + 100));
        wr(A_CTRL, 64'h1);
        for (int i = 0; i < 20 && busy; i++) step();
        chk("flush4_done", 64'(busy), 64'd0);
        rd("perf", A_PERF, 9'h00F, 1'b1, 64'd10);
`else
        rd("perf_absent", A_PERF, 9'h00F, 1'b0, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
